// File: rtl/cpu_pkg.sv
// Shared CPU encodings: opcodes, sequencer states, step width and control-strobe bundle.
// CU_BRANCH_EN adds the conditional branch opcode to the legal set.
package cpu_pkg;

  localparam int STEP_W = 4;
  localparam int OP_W   = 5;

  localparam logic [OP_W-1:0] OP_LD   = 5'b00000;
  localparam logic [OP_W-1:0] OP_LDI  = 5'b00001;
  localparam logic [OP_W-1:0] OP_ST   = 5'b00010;
  localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OP_W-1:0] OP_AND  = 5'b00101;
  localparam logic [OP_W-1:0] OP_OR   = 5'b00110;
  localparam logic [OP_W-1:0] OP_ADDI = 5'b01100;
  localparam logic [OP_W-1:0] OP_BR   = 5'b10010;
  localparam logic [OP_W-1:0] OP_JR   = 5'b10011;
  localparam logic [OP_W-1:0] OP_NOP  = 5'b11010;
  localparam logic [OP_W-1:0] OP_HALT = 5'b11011;

  localparam logic [STEP_W-1:0] STEP_FETCH_LAST = 4'd3;
  localparam logic [STEP_W-1:0] STEP_EXEC_FIRST = 4'd4;

  typedef enum logic [1:0] {RESET_ST, FETCH, EXEC, HALT_ST} state_t;

  typedef struct packed {
    logic pc_out, zlow_out, mdr_out, r_out, ba_out, csign_out;
    logic pc_in, mar_in, mdr_in, ir_in, y_in, zlow_in, r_in, con_in;
    logic gra, grb, grc;
    logic inc_pc, alu_add, alu_sub, alu_and, alu_or;
    logic mem_read, mem_write, md_read, mar_clear, run;
  } ctrl_t;

  // Final execute step per opcode; 0 means no execute phase (nop, halt, illegal).
  function automatic logic [STEP_W-1:0] last_step(input logic [OP_W-1:0] op);
    case (op)
      OP_LD:                                      return 4'd9;
      OP_ST:                                      return 4'd8;
      OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_ADDI:                                    return 4'd6;
      OP_JR:                                      return 4'd4;
`ifdef CU_BRANCH_EN
      OP_BR:                                      return 4'd7;
`endif
      default:                                    return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/cu_decode.sv
// Combinational strobe decode from {state, step, latched opcode, CON_FF}.
// CU_BRANCH_EN enables the br execute steps; otherwise CON_FF is ignored.
module cu_decode
  import cpu_pkg::*;
(
  input  state_t            state,
  input  logic [STEP_W-1:0] step,
  input  logic [OP_W-1:0]   op,
  input  logic              con_ff,
  output ctrl_t             ctrl
);

`ifndef CU_BRANCH_EN
  logic unused_con_ff;
  assign unused_con_ff = con_ff;
`endif

  always_comb begin
    ctrl = '0;
    case (state)
      RESET_ST: ctrl.mar_clear = 1'b1;
      FETCH: begin
        ctrl.run = 1'b1;
        case (step)
          4'd0: begin ctrl.pc_out = 1'b1; ctrl.mar_in = 1'b1; ctrl.inc_pc = 1'b1; ctrl.zlow_in = 1'b1; end
          4'd1: begin ctrl.zlow_out = 1'b1; ctrl.pc_in = 1'b1; ctrl.mem_read = 1'b1; end
          4'd2: begin ctrl.mdr_out = 1'b1; ctrl.md_read = 1'b1; ctrl.mdr_in = 1'b1; end
          4'd3: ctrl.ir_in = 1'b1;
          default: ;
        endcase
      end
      EXEC: begin
        ctrl.run = 1'b1;
        case (op)
          OP_LD, OP_LDI, OP_ST: begin
            case (step)
              4'd4: begin ctrl.grb = 1'b1; ctrl.ba_out = 1'b1; ctrl.y_in = 1'b1; end
              4'd5: begin ctrl.csign_out = 1'b1; ctrl.alu_add = 1'b1; ctrl.zlow_in = 1'b1; end
              4'd6: begin
                ctrl.zlow_out = 1'b1;
                if (op == OP_LDI) begin ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
                else              ctrl.mar_in = 1'b1;
              end
              4'd7: begin
                if (op == OP_LD)      ctrl.mem_read = 1'b1;
                else if (op == OP_ST) begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.mdr_in = 1'b1; end
              end
              4'd8: begin
                if (op == OP_LD)      begin ctrl.md_read = 1'b1; ctrl.mdr_in = 1'b1; end
                else if (op == OP_ST) ctrl.mem_write = 1'b1;
              end
              4'd9: if (op == OP_LD) begin ctrl.mdr_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
              default: ;
            endcase
          end
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: begin
            case (step)
              4'd4: begin ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.y_in = 1'b1; end
              4'd5: begin
                ctrl.zlow_in = 1'b1;
                if (op == OP_ADDI) begin
                  ctrl.csign_out = 1'b1;
                  ctrl.alu_add   = 1'b1;
                end else begin
                  ctrl.grc     = 1'b1;
                  ctrl.r_out   = 1'b1;
                  ctrl.alu_add = (op == OP_ADD);
                  ctrl.alu_sub = (op == OP_SUB);
                  ctrl.alu_and = (op == OP_AND);
                  ctrl.alu_or  = (op == OP_OR);
                end
              end
              4'd6: begin ctrl.zlow_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
              default: ;
            endcase
          end
          OP_JR: if (step == 4'd4) begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.pc_in = 1'b1; end
`ifdef CU_BRANCH_EN
          OP_BR: begin
            case (step)
              4'd4: begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.con_in = 1'b1; end
              4'd5: begin ctrl.pc_out = 1'b1; ctrl.y_in = 1'b1; end
              4'd6: begin ctrl.csign_out = 1'b1; ctrl.alu_add = 1'b1; ctrl.zlow_in = 1'b1; end
              4'd7: if (con_ff) begin ctrl.zlow_out = 1'b1; ctrl.pc_in = 1'b1; end
              default: ;
            endcase
          end
`endif
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired fetch/execute sequencer: holds state, step and latched opcode; strobes come from cu_decode.
module control_unit
  import cpu_pkg::*;
(
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] IR,
  input  logic        CON_FF,
  input  logic        Stop,
  output logic        PCout, Zlowout, MDRout, Rout, BAout, Csignout,
  output logic        PCin, MARin, MDRin, IRin, Yin, Zlowin, Rin, CONin,
  output logic        Gra, Grb, Grc,
  output logic        IncPC, ADD, SUB, AND, OR,
  output logic        Read, Write, MD_read,
  output logic        MAR_clear,
  output logic        Run
);

  state_t            state, state_nx;
  logic [STEP_W-1:0] step, step_nx;
  logic [OP_W-1:0]   op_q, op_nx;
  logic [OP_W-1:0]   ir_op;
  ctrl_t             ctrl;

  assign ir_op = IR[31:27];

  logic unused_ir;
  assign unused_ir = ^IR[26:0];

  always_ff @(posedge clock) begin
    if (clear) begin
      state <= RESET_ST;
      step  <= '0;
      op_q  <= '0;
    end else begin
      state <= state_nx;
      step  <= step_nx;
      op_q  <= op_nx;
    end
  end

  always_comb begin
    state_nx = state;
    step_nx  = step;
    op_nx    = op_q;
    case (state)
      RESET_ST: begin
        state_nx = FETCH;
        step_nx  = '0;
      end
      FETCH: begin
        if (step == STEP_FETCH_LAST) begin
          op_nx   = ir_op;
          step_nx = '0;
          // Opcodes without an execute phase go straight back to fetch.
          if (Stop || ir_op == OP_HALT)   state_nx = HALT_ST;
          else if (last_step(ir_op) == '0) state_nx = FETCH;
          else begin
            state_nx = EXEC;
            step_nx  = STEP_EXEC_FIRST;
          end
        end else begin
          step_nx = step + STEP_W'(1);
        end
      end
      EXEC: begin
        if (step >= last_step(op_q)) begin
          state_nx = FETCH;
          step_nx  = '0;
        end else begin
          step_nx = step + STEP_W'(1);
        end
      end
      HALT_ST: ;
      default: begin
        state_nx = RESET_ST;
        step_nx  = '0;
      end
    endcase
  end

  cu_decode u_decode (
    .state  (state),
    .step   (step),
    .op     (op_q),
    .con_ff (CON_FF),
    .ctrl   (ctrl)
  );

  assign PCout     = ctrl.pc_out;
  assign Zlowout   = ctrl.zlow_out;
  assign MDRout    = ctrl.mdr_out;
  assign Rout      = ctrl.r_out;
  assign BAout     = ctrl.ba_out;
  assign Csignout  = ctrl.csign_out;
  assign PCin      = ctrl.pc_in;
  assign MARin     = ctrl.mar_in;
  assign MDRin     = ctrl.mdr_in;
  assign IRin      = ctrl.ir_in;
  assign Yin       = ctrl.y_in;
  assign Zlowin    = ctrl.zlow_in;
  assign Rin       = ctrl.r_in;
  assign CONin     = ctrl.con_in;
  assign Gra       = ctrl.gra;
  assign Grb       = ctrl.grb;
  assign Grc       = ctrl.grc;
  assign IncPC     = ctrl.inc_pc;
  assign ADD       = ctrl.alu_add;
  assign SUB       = ctrl.alu_sub;
  assign AND       = ctrl.alu_and;
  assign OR        = ctrl.alu_or;
  assign Read      = ctrl.mem_read;
  assign Write     = ctrl.mem_write;
  assign MD_read   = ctrl.md_read;
  assign MAR_clear = ctrl.mar_clear;
  assign Run       = ctrl.run;

endmodule

// File: doc/control_unit.md
# control_unit

Hardwired control sequencer for the CPU datapath. Each cycle it steps through instruction fetch and per-opcode execute micro-steps and drives every datapath control strobe: bus-source selects, register enables, ALU op, memory read/write and Gra/Grb/Grc select. It sits beside DataPath and replaces the hand-written per-instruction stimulus sequences. It observes only IR and CON_FF.

## Interface
- No parameters. Opcode and step encodings come from the shared package.
- clock  in  1  system clock; all state changes on rising edge
- clear  in  1  reset; synchronous and active-high
- IR  in  32  instruction register contents; opcode = IR[31:27]
- CON_FF  in  1  branch condition flag from datapath CON logic
- Stop  in  1  request halt at next instruction boundary
- PCout, Zlowout, MDRout, Rout, BAout, Csignout  out  1 each  bus source selects
- PCin, MARin, MDRin, IRin, Yin, Zlowin, Rin, CONin  out  1 each  register load enables
- Gra, Grb, Grc  out  1 each  register-field selects for Rin/Rout/BAout
- IncPC, ADD, SUB, AND, OR  out  1 each  ALU operation
- Read, Write, MD_read  out  1 each  memory strobes; MD_read=1 selects memory into MDR, 0 selects bus
- MAR_clear  out  1  clears MAR
- Run  out  1  high while executing; low in RESET_ST and HALT_ST

## Operation
- Moore machine. Outputs are decoded from registered {state, step, latched opcode} only. Each step lasts exactly one clock. Outputs not listed for a step are 0.
- States: RESET_ST, FETCH, EXEC, HALT_ST. `step` is a 4-bit counter.
- RESET_ST: MAR_clear=1, Run=0. Goes to FETCH step 0 on the next clock.
- FETCH step 0: PCout, MARin, IncPC, Zlowin.
- FETCH step 1: Zlowout, PCin, Read.
- FETCH step 2: MDRout, MD_read, MDRin.
- FETCH step 3: IRin.
- After FETCH step 3, IR[31:27] is latched into `op_q`. If Stop=1 at that edge, go to HALT_ST. Otherwise go to EXEC step 4.
- Opcodes:
  - ld 00000: s4 Grb BAout Yin; s5 Csignout ADD Zlowin; s6 Zlowout MARin; s7 Read; s8 MD_read MDRin; s9 MDRout Gra Rin.
  - ldi 00001: s4 Grb BAout Yin; s5 Csignout ADD Zlowin; s6 Zlowout Gra Rin.
  - st 00010: s4–s6 as ld; s7 Gra Rout MDRin (MD_read=0); s8 Write.
  - add/sub/and/or 00011/00100/00101/00110: s4 Grb Rout Yin; s5 Grc Rout plus the matching ALU op and Zlowin; s6 Zlowout Gra Rin.
  - addi 01100: s4 Grb Rout Yin; s5 Csignout ADD Zlowin; s6 Zlowout Gra Rin.
  - jr 10011: s4 Gra Rout PCin.
  - nop 11010: no execute step; return to FETCH.
  - halt 11011: go to HALT_ST.
- After the last step of an opcode, the next state is FETCH step 0.
- Illegal opcode: treated as nop.
- HALT_ST: all strobes 0, Run=0. Exits only on clear.
- clear=1 in any state or step: at that edge, go to RESET_ST, step=0, op_q=0, all strobes 0. An in-flight instruction is abandoned. No partial Write is repeated.

## Timing
- Reset values: all strobes 0, MAR_clear=1, Run=0.
- First fetch strobes appear 1 cycle after clear deasserts.
- Cycles per instruction, including 4 fetch cycles: ld 10, ldi 7, st 9, ALU/addi 7, jr 5, nop 4, branch 8.
- Stop is sampled only at the end of FETCH step 3. Stop asserted mid-execute lets that instruction complete.
- Read and Write are single-cycle pulses. They are never high together.

## Configuration
- Macro: CU_BRANCH_EN.
- Defined: enables br opcode 10010.
  - s4 Gra Rout CONin.
  - s5 PCout Yin.
  - s6 Csignout ADD Zlowin.
  - s7 Zlowout PCin if CON_FF=1, else no strobes.
  - CON_FF is sampled during s7.
- Undefined: 10010 decodes as illegal, i.e. nop, and CON_FF is ignored.

## Structure
- Package `cpu_pkg`: 5-bit opcode constants, state enum, step width. DataPath decode reuses these.
- Sub-module `cu_decode`: purely combinational {state, step, op_q, CON_FF} to strobe vector.
- `control_unit` holds state, step and op_q, and instantiates `cu_decode`.

## Test plan
- **Reset:** clear held 3 cycles, then released. Expect MAR_clear=1 and Run=0 during clear and the next cycle. FETCH step 0 (PCout=MARin=IncPC=Zlowin=1) follows.
- **ldi:** IR=0x08800005 at FETCH step 3. Expect s4 Grb+BAout+Yin, s5 Csignout+ADD+Zlowin, s6 Zlowout+Gra+Rin. Next fetch starts 7 cycles after the previous one.
- **add:** IR=0x19890000. Expect s5 Grc+Rout+ADD+Zlowin with SUB/AND/OR=0. Repeat with opcode 00100; expect SUB only.
- **jr then halt:** IR=0x98800000 gives s4 Gra+Rout+PCin and a 5-cycle instruction. Then IR=0xD8000000 gives HALT_ST, Run=0, all strobes 0 for 20 cycles.
- **Branch (CU_BRANCH_EN defined):** IR=0x91000004. With CON_FF=1, s7 asserts Zlowout+PCin. With CON_FF=0, s7 strobes are 0. With the macro undefined, 4-cycle nop behaviour.
- **Mid-instruction reset:** clear during ld s7. Expect RESET_ST next cycle, no MDRin/Rin pulse, fetch restarts cleanly.
